aes_round_ctrl: RTL and testbench

//  Sequencer for AES-128 encryption. Drives the shared start/finish stage units (addkey, subbytes,

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_op_sched.sv | 36 +++
 rtl/aes_round_ctrl.sv | 155 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// Op encodings match the stage-unit select bus.
package aes_pkg;

  typedef enum logic [2:0] {
    OP_ADDKEY = 3'd0,
    OP_SUB    = 3'd1,
    OP_SHIFT  = 3'd2,
    OP_MIX    = 3'd3,
    OP_KEYEXP = 3'd4
  } aes_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_SKIP  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } ctrl_state_t;

  localparam int         AES_NROUNDS = 10;
  localparam logic [7:0] RCON0       = 8'h01;

  // GF(2^8) multiply-by-two, used to step the round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_op_sched.sv
// Combinational op sequencer: next op and last-op flag from the current round and op.
// The final round omits MIX and the ADDKEY of the final round ends the run.
module aes_op_sched
  import aes_pkg::*;
#(
  parameter int NROUNDS = AES_NROUNDS
) (
  input  logic [3:0] round,
  input  aes_op_t    op,
  output aes_op_t    next_op,
  output logic       last_op
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  // Next-op decode over the per-round op order
  always_comb begin
    next_op = OP_ADDKEY;
    last_op = 1'b0;
    case (op)
      OP_ADDKEY: begin
        next_op = OP_KEYEXP;
        last_op = (round == LAST_ROUND);
      end
      OP_KEYEXP: next_op = OP_SUB;
      OP_SUB:    next_op = OP_SHIFT;
      OP_SHIFT:  next_op = (round == LAST_ROUND) ? OP_ADDKEY : OP_MIX;
      OP_MIX:    next_op = OP_ADDKEY;
      default: begin
        next_op = OP_ADDKEY;
        last_op = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption sequencer: walks state and round key through the shared
// stage units over one multiplexed op bus, with a per-op watchdog.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int NROUNDS = AES_NROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         finish,
  output logic [127:0] out,
  output logic         error,
  output logic         busy,
  output logic         op_start,
  output logic [2:0]   op_sel,
  output logic [127:0] op_in,
  output logic [127:0] op_key,
  input  logic         op_finish,
  input  logic [127:0] op_result
);

  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  ctrl_state_t     fsm_r, fsm_nxt_s;
  aes_op_t         op_r, next_op_s;
  logic            last_op_s;
  logic            timeout_s;
  logic [127:0]    state_r, rk_r;
  logic [7:0]      rcon_r;
  logic [3:0]      round_r;
  logic [WD_W-1:0] wdog_r;

  aes_op_sched #(.NROUNDS(NROUNDS)) u_sched (
    .round   (round_r),
    .op      (op_r),
    .next_op (next_op_s),
    .last_op (last_op_s)
  );

  // Watchdog counts SKIP+WAIT cycles; the TIMEOUT-th such cycle aborts
  assign timeout_s = (wdog_r == WD_LAST);
  assign op_sel    = op_r;
  assign op_in     = (op_r == OP_KEYEXP) ? rk_r : state_r;

  // Key operand: round key for ADDKEY, round constant for KEYEXP
  always_comb begin
    op_key = 128'd0;
    case (op_r)
      OP_ADDKEY: op_key = rk_r;
      OP_KEYEXP: op_key = {120'd0, rcon_r};
      default:   op_key = 128'd0;
    endcase
  end

  // Next-state logic
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      ST_IDLE:  fsm_nxt_s = start ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: fsm_nxt_s = ST_SKIP;
      ST_SKIP:  fsm_nxt_s = timeout_s ? ST_ABORT : ST_WAIT;
      ST_WAIT: begin
        if (op_finish) begin
          fsm_nxt_s = last_op_s ? ST_DONE : ST_ISSUE;
        end else if (timeout_s) begin
          fsm_nxt_s = ST_ABORT;
        end else begin
          fsm_nxt_s = ST_WAIT;
        end
      end
      ST_DONE:  fsm_nxt_s = ST_IDLE;
      ST_ABORT: fsm_nxt_s = ST_IDLE;
      default:  fsm_nxt_s = ST_IDLE;
    endcase
  end

  // State register and the one-cycle op_start pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_r    <= ST_IDLE;
      op_start <= 1'b0;
    end else begin
      fsm_r    <= fsm_nxt_s;
      op_start <= (fsm_nxt_s == ST_ISSUE);
    end
  end

  // Datapath, schedule counters, watchdog and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= 128'd0;
      rk_r    <= 128'd0;
      rcon_r  <= RCON0;
      round_r <= 4'd0;
      op_r    <= OP_ADDKEY;
      wdog_r  <= '0;
      out     <= 128'd0;
      finish  <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= in;
            rk_r    <= key;
            round_r <= 4'd0;
            rcon_r  <= RCON0;
            op_r    <= OP_ADDKEY;
            finish  <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_ISSUE: wdog_r <= '0;
        ST_SKIP:  wdog_r <= wdog_r + WD_W'(1);
        ST_WAIT: begin
          if (op_finish) begin
            if (op_r == OP_KEYEXP) begin
              rk_r   <= op_result;
              rcon_r <= xtime(rcon_r);
            end else begin
              state_r <= op_result;
            end
            if (op_r == OP_ADDKEY) begin
              round_r <= round_r + 4'd1;
            end
            op_r <= next_op_s;
          end else begin
            wdog_r <= wdog_r + WD_W'(1);
          end
        end
        ST_DONE: begin
          out    <= state_r;
          finish <= 1'b1;
          busy   <= 1'b0;
        end
        ST_ABORT: begin
          error  <= 1'b1;
          finish <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with behavioural AES stage units on the op bus.
// Ciphertexts and op order come from the bench's scoreboard queues.
module tb_aes_round_ctrl;

  localparam int TO = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] in_v = 128'd0;
  logic [127:0] key_v = 128'd0;
  logic         finish, error, busy, op_start;
  logic [127:0] out_v, op_in, op_key;
  logic [2:0]   op_sel;
  logic         op_finish = 1'b0;
  logic [127:0] op_result = 128'd0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_q[$];
  logic [10:0]  op_q[$];
  int n_opstart = 0;
  int fin_rise  = 0;
  int cyc       = 0;
  int last_op_cyc = 0;

  int model_ops = 0;
  int stall_at  = -1;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  aes_round_ctrl #(.TIMEOUT(TO), .NROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in_v),
    .key       (key_v),
    .finish    (finish),
    .out       (out_v),
    .error     (error),
    .busy      (busy),
    .op_start  (op_start),
    .op_sel    (op_sel),
    .op_in     (op_in),
    .op_key    (op_key),
    .op_finish (op_finish),
    .op_result (op_result)
  );

  always #5 clk = ~clk;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = x;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] v);
    logic [127:0] o;
    o = 128'd0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(gb(v, i));
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] v);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gb(v, r + 4*((c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(v, 4*c); a1 = gb(v, 4*c+1); a2 = gb(v, 4*c+2); a3 = gb(v, 4*c+3);
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] stage(input logic [2:0] sel, input logic [127:0] v,
                                         input logic [127:0] k);
    case (sel)
      3'd0:    return v ^ k;
      3'd1:    return sub_bytes(v);
      3'd2:    return shift_rows(v);
      3'd3:    return mix_cols(v);
      3'd4:    return key_exp(v, k[7:0]);
      default: return 128'd0;
    endcase
  endfunction

  // ---------------- behavioural stage unit ----------------
  logic [2:0]   m_sel = 3'd0;
  logic [127:0] m_in = 128'd0, m_key = 128'd0;
  int           m_cnt = 0;
  logic         m_pend = 1'b0, m_first = 1'b0, m_stall = 1'b0;

  // Finish stays high one cycle past op_start so stale results land in SKIP
  always @(posedge clk) begin
    if (!rst) begin
      op_finish <= 1'b0;
      m_pend    <= 1'b0;
      m_first   <= 1'b0;
    end else if (op_start) begin
      m_pend    <= 1'b1;
      m_first   <= 1'b1;
      m_cnt     <= $urandom_range(0, 3);
      m_sel     <= op_sel;
      m_in      <= op_in;
      m_key     <= op_key;
      m_stall   <= ((model_ops + 1) == stall_at);
      model_ops <= model_ops + 1;
    end else if (m_pend) begin
      if (m_first) begin
        op_finish <= 1'b0;
        m_first   <= 1'b0;
      end else if (!m_stall) begin
        if (m_cnt == 0) begin
          op_finish <= 1'b1;
          op_result <= stage(m_sel, m_in, m_key);
          m_pend    <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_ops();
    logic [7:0] rc[10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    op_q.push_back({3'd0, 8'h00});
    for (int r = 1; r <= 10; r++) begin
      op_q.push_back({3'd4, rc[r-1]});
      op_q.push_back({3'd1, 8'h00});
      op_q.push_back({3'd2, 8'h00});
      if (r < 10) op_q.push_back({3'd3, 8'h00});
      op_q.push_back({3'd0, 8'h00});
    end
  endtask

  // Op-bus monitor: pops the expected op order on each op_start
  initial begin
    logic [10:0] e;
    logic fin_d;
    fin_d = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && op_start) begin
        n_opstart++;
        last_op_cyc = cyc;
        if (op_q.size() == 0) begin
          chk("op_unexpected", {127'd0, op_start}, 128'd0);
        end else begin
          e = op_q.pop_front();
          chk("op_sel", {125'd0, op_sel}, {125'd0, e[10:8]});
          if (e[10:8] == 3'd4) chk("op_key_rcon", op_key, {120'd0, e[7:0]});
        end
      end
      if (finish && !fin_d) fin_rise++;
      fin_d = finish;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] p, input int hold);
    key_v = k;
    in_v  = p;
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    bit seen;
    logic [127:0] e;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (finish) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL %s_timeout: finish observed 0 expected 1 within 2000 cycles", tag);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'd0;
    if (seen) chk(tag, out_v, e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ops0, rise0, delta;
    bit seen;

    // reset values
    repeat (3) tick();
    chk("rst_finish", {127'd0, finish}, 128'd0);
    chk("rst_error", {127'd0, error}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_op_start", {127'd0, op_start}, 128'd0);
    chk("rst_op_sel", {125'd0, op_sel}, 128'd0);
    chk("rst_out", out_v, 128'd0);
    rst = 1'b1;
    repeat (2) tick();

    // test 1 + 3: FIPS vector, start held two cycles, op order and count
    exp_q.push_back(C1);
    push_ops();
    ops0 = n_opstart;
    do_start(K1, P1, 2);
    chk("t1_busy", {127'd0, busy}, 128'd1);
    wait_finish("t1_out");
    chk("t1_busy_done", {127'd0, busy}, 128'd0);
    chk("t1_error", {127'd0, error}, 128'd0);
    chk("t3_op_count", 128'(n_opstart - ops0), 128'd50);
    chk("t3_op_q_empty", 128'(op_q.size()), 128'd0);
    repeat (5) tick();
    chk("t1_finish_held", {127'd0, finish}, 128'd1);
    chk("t1_out_stable", out_v, C1);

    // test 2: second vector
    exp_q.push_back(C2);
    push_ops();
    do_start(K2, P2, 1);
    chk("t2_finish_cleared", {127'd0, finish}, 128'd0);
    wait_finish("t2_out");

    // test 4: start pulse mid-run is ignored
    exp_q.push_back(C1);
    push_ops();
    rise0 = fin_rise;
    do_start(K1, P1, 1);
    repeat (40) tick();
    do_start(K2, P2, 1);
    chk("t4_busy", {127'd0, busy}, 128'd1);
    wait_finish("t4_out");
    repeat (5) tick();
    chk("t4_single_finish", 128'(fin_rise - rise0), 128'd1);
    chk("t4_finish_held", {127'd0, finish}, 128'd1);

    // test 5: unit never finishes op 7 -> watchdog abort
    push_ops();
    ops0 = n_opstart;
    stall_at = model_ops + 7;
    do_start(K1, P1, 1);
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (error) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_error", {127'd0, error}, 128'd1);
    delta = cyc - last_op_cyc;
    n_tests++;
    assert (seen && delta >= TO && delta <= TO + 4) else begin
      n_fail++;
      $error("FAIL t5_abort_latency: observed %0d expected %0d..%0d", delta, TO, TO + 4);
    end
    chk("t5_busy", {127'd0, busy}, 128'd0);
    chk("t5_finish", {127'd0, finish}, 128'd0);
    chk("t5_out_kept", out_v, C1);
    repeat (20) tick();
    chk("t5_op_count", 128'(n_opstart - ops0), 128'd7);
    chk("t5_error_held", {127'd0, error}, 128'd1);
    op_q.delete();
    stall_at = -1;

    // test 6: reset mid-run, then a fresh run
    push_ops();
    do_start(K1, P1, 1);
    repeat (30) tick();
    rst = 1'b0;
    tick();
    chk("t6_rst_busy", {127'd0, busy}, 128'd0);
    chk("t6_rst_finish", {127'd0, finish}, 128'd0);
    chk("t6_rst_error", {127'd0, error}, 128'd0);
    chk("t6_rst_op_start", {127'd0, op_start}, 128'd0);
    chk("t6_rst_op_sel", {125'd0, op_sel}, 128'd0);
    chk("t6_rst_out", out_v, 128'd0);
    repeat (2) tick();
    rst = 1'b1;
    op_q.delete();
    repeat (2) tick();
    exp_q.push_back(C2);
    push_ops();
    do_start(K2, P2, 1);
    wait_finish("t6_out");
    chk("t6_error", {127'd0, error}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
